// File: rtl/imem_pkg.sv
// Shared defaults, debug-state encoding and byte helper
// for the instruction-memory arbiter.
package imem_pkg;

    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_WAIT = 2'b01,
        D_ACK  = 2'b10
    } dbg_state_e;

    // Pick one byte lane of a 32-bit word for the LED readout.
    function automatic logic [7:0] byte_sel(
        input logic [31:0] w,
        input logic [1:0]  sel
    );
        logic [7:0] b;
        case (sel)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of CPU fetch, debug port and memory bus signals.
// slave = arbiter view, master = surrounding system view.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_valid;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [1:0]        dbg_bytesel;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic [7:0]        dbg_led;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_bytesel,
        input  mem_rdata,
        output cpu_rdata, cpu_valid, cpu_stall,
        output dbg_ack, dbg_rdata, dbg_led,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_addr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_bytesel,
        output mem_rdata,
        input  cpu_rdata, cpu_valid, cpu_stall,
        input  dbg_ack, dbg_rdata, dbg_led,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_dbg_fsm.sv
// Debug-port sequencer (IDLE/WAIT/ACK) plus the starvation
// counter that lets debug pre-empt a busy CPU.
module imem_dbg_fsm
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dbg_req_i,
    input  logic       dbg_gnt_i,
    input  logic       dbg_we_i,
    input  logic [1:0] dbg_bytesel_i,
    output logic       eligible_o,
    output logic       starve_hit_o,
    output logic       capture_o,
    output logic       ack_o,
    output logic [1:0] bytesel_o
);

    localparam int CNT_W =
        (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    dbg_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             we_q, we_d;
    logic [1:0]       bytesel_q, bytesel_d;

    assign eligible_o   = dbg_req_i && (state_q == D_IDLE);
    assign starve_hit_o = (starve_q == CNT_MAX);
    assign capture_o    = (state_q == D_WAIT) && !we_q;
    assign ack_o        = (state_q == D_ACK);
    assign bytesel_o    = bytesel_q;

    // Sequence one debug op; latch its type and byte lane on grant.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        bytesel_d = bytesel_q;
        unique case (state_q)
            D_IDLE: begin
                if (dbg_gnt_i) begin
                    state_d   = D_WAIT;
                    we_d      = dbg_we_i;
                    bytesel_d = dbg_bytesel_i;
                end
            end
            D_WAIT:  state_d = D_ACK;
            D_ACK:   state_d = D_IDLE;
            default: state_d = D_IDLE;
        endcase
    end

    // Count cycles debug is ready but losing to the CPU.
    always_comb begin
        starve_d = starve_q;
        if (!dbg_req_i || dbg_gnt_i) begin
            starve_d = '0;
        end else if (eligible_o && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers, cleared straight away by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= D_IDLE;
            starve_q  <= '0;
            we_q      <= 1'b0;
            bytesel_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            we_q      <= we_d;
            bytesel_q <= bytesel_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by CPU fetch and a
// debug port; CPU has priority until debug starves.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic           clk,
    input logic           rst,
    imem_arbiter_if.slave bus
);

    logic              dbg_eligible;
    logic              starve_hit;
    logic              dbg_capture;
    logic              dbg_ack;
    logic [1:0]        dbg_bytesel_q;
    logic              dbg_gnt;
    logic              cpu_gnt;

    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    logic              cpu_valid_q;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [7:0]        dbg_led_q, dbg_led_d;

    imem_dbg_fsm #(
        .STARVE_MAX (STARVE_MAX)
    ) u_dbg_fsm (
        .clk           (clk),
        .rst_n         (rst),
        .dbg_req_i     (bus.dbg_req),
        .dbg_gnt_i     (dbg_gnt),
        .dbg_we_i      (bus.dbg_we),
        .dbg_bytesel_i (bus.dbg_bytesel),
        .eligible_o    (dbg_eligible),
        .starve_hit_o  (starve_hit),
        .capture_o     (dbg_capture),
        .ack_o         (dbg_ack),
        .bytesel_o     (dbg_bytesel_q)
    );

    // Grant: CPU wins unless debug has waited long enough.
    // Nothing is granted while reset is held.
    always_comb begin
        dbg_gnt = rst && dbg_eligible
                  && (!bus.cpu_req || starve_hit);
        cpu_gnt = rst && bus.cpu_req && !dbg_gnt;
    end

    // Steer the granted requester onto the memory bus.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (dbg_gnt) begin
            addr_mux  = bus.dbg_addr;
            wdata_mux = bus.dbg_wdata;
        end else if (cpu_gnt) begin
            addr_mux  = bus.cpu_addr;
        end
    end

    assign bus.mem_en    = cpu_gnt || dbg_gnt;
    assign bus.mem_we    = dbg_gnt && bus.dbg_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.cpu_stall = rst && bus.cpu_req && !cpu_gnt;

    // Fetch data passes straight through in the valid cycle,
    // then the hold register keeps it stable until the next one.
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.cpu_rdata = cpu_valid_q ? bus.mem_rdata : cpu_hold_q;

    // Keep the last fetched word once the valid cycle ends.
    always_comb begin
        cpu_hold_d = cpu_hold_q;
        if (cpu_valid_q) begin
            cpu_hold_d = bus.mem_rdata;
        end
    end

    // Capture debug read data and its byte lane in the wait cycle;
    // writes leave the readout untouched.
    always_comb begin
        dbg_rdata_d = dbg_rdata_q;
        dbg_led_d   = dbg_led_q;
        if (dbg_capture) begin
            dbg_rdata_d = bus.mem_rdata;
            dbg_led_d   = byte_sel(bus.mem_rdata[31:0], dbg_bytesel_q);
        end
    end

    assign bus.dbg_ack   = dbg_ack;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_led   = dbg_led_q;

    // Response registers; reset drops any pending valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_valid_q <= 1'b0;
            cpu_hold_q  <= '0;
            dbg_rdata_q <= '0;
            dbg_led_q   <= 8'h00;
        end else begin
            cpu_valid_q <= cpu_gnt;
            cpu_hold_q  <= cpu_hold_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_led_q   <= dbg_led_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed scenarios then
// random CPU/debug traffic against a cycle-level reference model.
module tb_imem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 4;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  led;
        int          due;
    } exp_t;

    logic clk;
    logic rst;

    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit started = 0;

    exp_t cpu_q[$];
    exp_t dbg_q[$];

    logic [31:0] ref_mem [32];
    int          m_busy;
    int          m_wait;
    logic [31:0] m_rdata;
    logic [7:0]  m_led;

    logic          exp_stall, exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;

    bit            d_active;
    int            d_ack_due;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [1:0]    d_bs;

    logic [31:0] last_cpu, last_dbg;
    logic [7:0]  last_led;
    logic [31:0] mem_rdata_r;

    function automatic logic [31:0] init_word(input int n);
        if (n < 4) return 32'h2008_0000 + 32'(n);
        if (n == 5) return 32'h1234_5678;
        return 32'hA500_0000 ^ (32'(n) * 32'h0101_0101);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Synchronous single-port memory, one-cycle read latency.
    initial begin
        logic [31:0] mem [32];
        for (int i = 0; i < 32; i++) mem[i] = init_word(i);
        mem_rdata_r = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                mem_rdata_r <= mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = 0;
            bus.cpu_req     = 1;
            bus.dbg_req     = 1;
            bus.dbg_we      = 1;
            bus.cpu_addr    = 5'd7;
            bus.dbg_addr    = 5'd9;
            bus.dbg_wdata   = 32'hFFFF_FFFF;
            bus.dbg_bytesel = 2'b11;
            cpu_q.delete();
            dbg_q.delete();
            m_busy    = 0;
            m_wait    = 0;
            m_rdata   = '0;
            m_led     = '0;
            d_active  = 0;
            d_ack_due = -1;
            started   = 1;
        end
    endtask

    // Drive one cycle and predict the arbiter's response.
    task automatic step(input logic c_req, input logic [AW-1:0] c_addr,
                        input logic d_req);
        logic elig, dg, cg;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1;
        bus.cpu_req     = c_req;
        bus.cpu_addr    = c_addr;
        bus.dbg_req     = d_req;
        bus.dbg_we      = d_we;
        bus.dbg_addr    = d_addr;
        bus.dbg_wdata   = d_wdata;
        bus.dbg_bytesel = d_bs;

        elig = d_req && (m_busy == 0);
        dg   = elig && (!c_req || m_wait >= SM);
        cg   = c_req && !dg;

        exp_stall = c_req && !cg;
        exp_en    = cg || dg;
        exp_we    = dg && d_we;
        exp_addr  = dg ? d_addr : c_addr;
        exp_wdata = d_wdata;

        if (cg) cpu_q.push_back('{ref_mem[c_addr], 8'h00, cyc + 1});
        if (dg) begin
            if (d_we) begin
                ref_mem[d_addr] = d_wdata;
            end else begin
                m_rdata = ref_mem[d_addr];
                m_led   = 8'(m_rdata >> (8 * int'(d_bs)));
            end
            dbg_q.push_back('{m_rdata, m_led, cyc + 2});
            d_ack_due = cyc + 2;
        end

        if (dg) m_busy = 2;
        else if (m_busy > 0) m_busy = m_busy - 1;
        if (!d_req || dg) m_wait = 0;
        else if (elig) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
    endtask

    task automatic dbg_start(input logic we, input logic [AW-1:0] a,
                             input logic [31:0] wd, input logic [1:0] bs);
        d_active  = 1;
        d_ack_due = -1;
        d_we      = we;
        d_addr    = a;
        d_wdata   = wd;
        d_bs      = bs;
    endtask

    // Debug requester: holds req through the ack cycle, drops it
    // for one cycle afterwards, optionally launches random ops.
    task automatic cyc_go(input logic c_req, input logic [AW-1:0] c_addr,
                          input bit allow_new);
        logic dreq;
        if (d_active && d_ack_due >= 0 && cyc + 1 > d_ack_due) begin
            d_active = 0;
            dreq     = 0;
        end else begin
            if (!d_active && allow_new && $urandom_range(0, 3) == 0)
                dbg_start(1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 7)),
                          $urandom, 2'($urandom_range(0, 3)));
            dreq = d_active;
        end
        step(c_req, c_addr, dreq);
    endtask

    // Monitor: compares bus outputs and pops expected responses.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (!rst) begin
                chk("rst_ctl",
                    64'({bus.cpu_valid, bus.cpu_stall, bus.dbg_ack,
                         bus.mem_en, bus.mem_we, bus.dbg_led}), 64'(0));
                chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
                chk("rst_dbg_rdata", 64'(bus.dbg_rdata), 64'(0));
                last_cpu = '0;
                last_dbg = '0;
                last_led = '0;
            end else begin
                chk("cpu_stall", 64'(bus.cpu_stall), 64'(exp_stall));
                chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
                chk("mem_we", 64'(bus.mem_we), 64'(exp_we));
                if (exp_en) chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                if (exp_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));

                if (bus.cpu_valid) begin
                    if (cpu_q.size() == 0) begin
                        chk("cpu_valid_spurious", 64'(bus.cpu_valid), 64'(0));
                    end else begin
                        e = cpu_q.pop_front();
                        chk("cpu_valid_cycle", 64'(cyc), 64'(e.due));
                        chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.data));
                        last_cpu = e.data;
                    end
                end else begin
                    chk("cpu_rdata_hold", 64'(bus.cpu_rdata), 64'(last_cpu));
                    if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                        chk("cpu_valid_missing", 64'(bus.cpu_valid), 64'(1));
                        void'(cpu_q.pop_front());
                    end
                end

                if (bus.dbg_ack) begin
                    if (dbg_q.size() == 0) begin
                        chk("dbg_ack_spurious", 64'(bus.dbg_ack), 64'(0));
                    end else begin
                        e = dbg_q.pop_front();
                        chk("dbg_ack_cycle", 64'(cyc), 64'(e.due));
                        chk("dbg_rdata", 64'(bus.dbg_rdata), 64'(e.data));
                        chk("dbg_led", 64'(bus.dbg_led), 64'(e.led));
                        last_dbg = e.data;
                        last_led = e.led;
                    end
                end else begin
                    chk("dbg_rdata_hold", 64'(bus.dbg_rdata), 64'(last_dbg));
                    chk("dbg_led_hold", 64'(bus.dbg_led), 64'(last_led));
                    if (dbg_q.size() != 0 && dbg_q[0].due <= cyc) begin
                        chk("dbg_ack_missing", 64'(bus.dbg_ack), 64'(1));
                        void'(dbg_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1;
        bus.cpu_req     = 0;
        bus.cpu_addr    = '0;
        bus.dbg_req     = 0;
        bus.dbg_we      = 0;
        bus.dbg_addr    = '0;
        bus.dbg_wdata   = '0;
        bus.dbg_bytesel = '0;
        d_we = 0; d_addr = '0; d_wdata = '0; d_bs = '0;
        d_active = 0; d_ack_due = -1;
        m_busy = 0; m_wait = 0; m_rdata = '0; m_led = '0;
        exp_stall = 0; exp_en = 0; exp_we = 0;
        exp_addr = '0; exp_wdata = '0;
        last_cpu = '0; last_dbg = '0; last_led = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

        // Reset with every request high, then CPU stream while
        // a debug read of word 5 waits and finally pre-empts.
        do_reset(3);
        dbg_start(0, 5'd5, 32'h0, 2'b01);
        for (int i = 0; i < 9; i++) cyc_go(1, AW'(i), 0);

        // Debug write, then CPU reads the same word after the ack.
        dbg_start(1, 5'd3, 32'hDEAD_BEEF, 2'b00);
        for (int i = 0; i < 4; i++) cyc_go(0, '0, 0);
        cyc_go(1, 5'd3, 0);
        cyc_go(0, '0, 0);

        // Debug write followed immediately by a CPU read.
        dbg_start(1, 5'd6, 32'hCAFE_F00D, 2'b10);
        cyc_go(0, '0, 0);
        cyc_go(1, 5'd6, 0);
        for (int i = 0; i < 3; i++) cyc_go(0, '0, 0);

        // Reset while a debug read sits in its wait cycle.
        dbg_start(0, 5'd5, 32'h0, 2'b11);
        cyc_go(0, '0, 0);
        do_reset(2);
        dbg_start(0, 5'd2, 32'h0, 2'b10);
        for (int i = 0; i < 8; i++) cyc_go(1, AW'(i), 0);

        // Random mixed traffic.
        for (int i = 0; i < 600; i++)
            cyc_go(1'($urandom_range(0, 3) != 0),
                   AW'($urandom_range(0, 7)), 1);

        for (int i = 0; i < 8; i++) cyc_go(0, '0, 0);
        @(negedge clk);
        #1;
        chk("drain_cpu_q", 64'(cpu_q.size()), 64'(0));
        chk("drain_dbg_q", 64'(dbg_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
